// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: packs WORD_W bits of a shared LFSR stream into a word and
// hands each word to one requester, chosen round-robin.
// Optional build macro: LFSR_ARB_PREFETCH_EN keeps a word buffered ahead of
// demand (HOLD state) so a request can be served without waiting for a fill.
module lfsr_rand_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WORD_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               lfsr_bit_i,
    output logic               lfsr_en_o,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [WORD_W-1:0]  rand_o,
    output logic               rand_valid_o,
    output logic               busy_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

`ifdef LFSR_ARB_PREFETCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DELIVER = 2'd2, HOLD = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DELIVER = 2'd2} state_e;
`endif

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   win_idx_q, win_idx_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [WORD_W-1:0]  rand_q, rand_d;
    logic               valid_q, valid_d;
    logic               lfsr_en_q, lfsr_en_d;
    logic               busy_q, busy_d;
`ifdef LFSR_ARB_PREFETCH_EN
    logic               win_vld_q, win_vld_d;
`endif

    logic               req_any;
    logic [IDX_W-1:0]   pick_idx;

    // Round-robin search: first set request at rr_ptr, rr_ptr+1, ... wrapping.
    always_comb begin
        req_any  = 1'b0;
        pick_idx = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!req_any && req_i[IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ)]) begin
                req_any  = 1'b1;
                pick_idx = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_idx_d = win_idx_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        gnt_d     = '0;
        rand_d    = '0;
        valid_d   = 1'b0;
`ifdef LFSR_ARB_PREFETCH_EN
        win_vld_d = win_vld_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef LFSR_ARB_PREFETCH_EN
                // Start prefetching immediately; latch a winner if one is waiting.
                state_d   = FILL;
                win_vld_d = req_any;
                if (req_any) begin
                    win_idx_d = pick_idx;
                end
`else
                if (req_any) begin
                    win_idx_d = pick_idx;
                    state_d   = FILL;
                end
`endif
            end
            FILL: begin
                // First sampled bit migrates up to the MSB.
                shreg_d   = WORD_W'({shreg_q, lfsr_bit_i});
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef LFSR_ARB_PREFETCH_EN
                if (!win_vld_q && req_any) begin
                    win_idx_d = pick_idx;
                    win_vld_d = 1'b1;
                end
`endif
                if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                    bit_cnt_d = '0;
`ifdef LFSR_ARB_PREFETCH_EN
                    state_d   = win_vld_d ? DELIVER : HOLD;
`else
                    state_d   = DELIVER;
`endif
                end
            end
            DELIVER: begin
                gnt_d     = NUM_REQ'(1) << win_idx_q;
                rand_d    = shreg_q;
                valid_d   = 1'b1;
                rr_ptr_d  = IDX_W'((32'(win_idx_q) + 1) % NUM_REQ);
                bit_cnt_d = '0;
`ifdef LFSR_ARB_PREFETCH_EN
                win_vld_d = 1'b0;
                state_d   = FILL;
`else
                state_d   = IDLE;
`endif
            end
`ifdef LFSR_ARB_PREFETCH_EN
            HOLD: begin
                // Word already buffered: arbitrate and deliver straight away.
                if (req_any) begin
                    win_idx_d = pick_idx;
                    win_vld_d = 1'b1;
                    state_d   = DELIVER;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        lfsr_en_d = (state_d == FILL);
`ifdef LFSR_ARB_PREFETCH_EN
        busy_d    = (state_d == DELIVER) || ((state_d == FILL) && win_vld_d);
`else
        busy_d    = (state_d != IDLE);
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            win_idx_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            gnt_q     <= '0;
            rand_q    <= '0;
            valid_q   <= 1'b0;
            lfsr_en_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef LFSR_ARB_PREFETCH_EN
            win_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_idx_q <= win_idx_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            gnt_q     <= gnt_d;
            rand_q    <= rand_d;
            valid_q   <= valid_d;
            lfsr_en_q <= lfsr_en_d;
            busy_q    <= busy_d;
`ifdef LFSR_ARB_PREFETCH_EN
            win_vld_q <= win_vld_d;
`endif
        end
    end

    assign lfsr_en_o    = lfsr_en_q;
    assign gnt_o        = gnt_q;
    assign rand_o       = rand_q;
    assign rand_valid_o = valid_q;
    assign busy_o       = busy_q;

endmodule
